// File: rtl/grant_channel_ctrl.sv
// Purpose: grants one of eight IDs exclusive use of a channel, with a forced release after MAX_HOLD cycles and GUARD idle cycles between owners.
// Latency: the channel enable, owner and busy change on the same edge that samples the grant; the done and timeout pulses follow the exit edge.
// Backpressure: there is no queue. A grant that arrives in HOLD or GUARD is dropped, and the arbiter must present it again once the block is IDLE.
module grant_channel_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int GUARD    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] grant,
    input  logic [7:0] release_i,
    input  logic [2:0] rd_sel,
    output logic [7:0] ch_en,
    output logic [2:0] owner_id,
    output logic       busy,
    output logic       done_pulse,
    output logic       timeout_pulse,
    output logic [7:0] served_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);
    localparam logic [3:0] GUARD_LAST = 4'((GUARD > 0) ? (GUARD - 1) : 0);
    localparam bit         HAS_GUARD  = (GUARD > 0);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_guard_cnt;
    logic [2:0] r_owner;
    logic       r_done;
    logic       r_timeout;
    logic [7:0] r_served [8];

    logic       w_rel;
    logic       w_hold_exp;
    logic       w_accept;
    logic       w_exit;

    // Only the release bit of the current owner matters. A release takes priority over the timeout.
    assign w_rel      = release_i[r_owner];
    assign w_hold_exp = (r_hold_cnt == HOLD_LAST);
    assign w_accept   = (r_state == S_IDLE) && grant[3];
    assign w_exit     = (r_state == S_HOLD) && (w_rel || w_hold_exp);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. When there is no guard interval, HOLD returns straight to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (grant[3]) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_rel || w_hold_exp) begin
                    w_next_state = HAS_GUARD ? S_GUARD : S_IDLE;
                end
            end
            S_GUARD: begin
                if (r_guard_cnt == GUARD_LAST) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Hold and guard counters, latched owner, and exit pulses registered for the cycle after the exit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt  <= 8'd0;
            r_guard_cnt <= 4'd0;
            r_owner     <= 3'd0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_cnt <= 8'd0;
                r_owner    <= grant[2:0];
            end else if ((r_state == S_HOLD) && !w_exit) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end

            if (w_exit) begin
                r_guard_cnt <= 4'd0;
            end else if (r_state == S_GUARD) begin
                r_guard_cnt <= r_guard_cnt + 4'd1;
            end

            r_done    <= w_exit && w_rel;
            r_timeout <= w_exit && !w_rel;
        end
    end

    // Per-ID served counters, which saturate at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_served[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_accept && (grant[2:0] == 3'(k)) && (r_served[k] != 8'hFF)) begin
                    r_served[k] <= r_served[k] + 8'd1;
                end
            end
        end
    end

    // Output decode from the registered state
    always_comb begin
        ch_en = 8'h00;
        if (r_state == S_HOLD) begin
            ch_en = 8'h01 << r_owner;
        end
        busy          = (r_state != S_IDLE);
        owner_id      = r_owner;
        done_pulse    = r_done;
        timeout_pulse = r_timeout;
        served_cnt    = r_served[rd_sel];
    end

endmodule

// File: tb/tb_grant_channel_ctrl.sv
module tb_grant_channel_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] grant;
    logic [7:0] release_i;
    logic [2:0] rd_sel;
    logic [7:0] ch_en;
    logic [2:0] owner_id;
    logic       busy;
    logic       done_pulse;
    logic       timeout_pulse;
    logic [7:0] served_cnt;

    int checks = 0;
    int errors = 0;

    grant_channel_ctrl #(.MAX_HOLD(16), .GUARD(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .grant        (grant),
        .release_i    (release_i),
        .rd_sel       (rd_sel),
        .ch_en        (ch_en),
        .owner_id     (owner_id),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .timeout_pulse(timeout_pulse),
        .served_cnt   (served_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle slightly after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        grant     = 4'h0;
        release_i = 8'h00;
        rd_sel    = 3'd0;

        // Reset state
        step();
        step();
        chk("rst_ch_en", 32'(ch_en), 32'h00);
        chk("rst_owner", 32'(owner_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_tmo", 32'(timeout_pulse), 32'd0);
        chk("rst_served", 32'(served_cnt), 32'd0);

        // The first grant is taken on the first edge after reset is released
        rst_n  = 1'b1;
        grant  = 4'b1111;
        rd_sel = 3'd7;
        step();
        chk("g7_ch_en", 32'(ch_en), 32'h80);
        chk("g7_owner", 32'(owner_id), 32'd7);
        chk("g7_busy", 32'(busy), 32'd1);
        chk("g7_served", 32'(served_cnt), 32'd1);
        grant     = 4'h0;
        release_i = 8'h80;
        step();
        chk("r7_ch_en", 32'(ch_en), 32'h00);
        chk("r7_done", 32'(done_pulse), 32'd1);
        release_i = 8'h00;
        step();
        step();
        chk("r7_idle_busy", 32'(busy), 32'd0);
        chk("r7_owner_kept", 32'(owner_id), 32'd7);

        // Owner 2 is released after 3 cycles, followed by two guard cycles
        grant  = 4'b1010;
        rd_sel = 3'd2;
        step();
        chk("g2_ch_en", 32'(ch_en), 32'h04);
        chk("g2_served", 32'(served_cnt), 32'd1);
        grant = 4'h0;
        step();
        step();
        release_i = 8'h04;
        step();
        chk("r2_ch_en", 32'(ch_en), 32'h00);
        chk("r2_done", 32'(done_pulse), 32'd1);
        chk("r2_tmo", 32'(timeout_pulse), 32'd0);
        chk("r2_guard1_busy", 32'(busy), 32'd1);
        release_i = 8'h00;
        step();
        chk("r2_guard2_busy", 32'(busy), 32'd1);
        chk("r2_done_once", 32'(done_pulse), 32'd0);
        // A grant on the edge that re-enters IDLE is not accepted
        grant = 4'b1101;
        step();
        chk("g5_blocked_busy", 32'(busy), 32'd0);
        chk("g5_blocked_ch_en", 32'(ch_en), 32'h00);
        chk("g5_blocked_owner", 32'(owner_id), 32'd2);
        step();
        chk("g5_ch_en", 32'(ch_en), 32'h20);
        chk("g5_owner", 32'(owner_id), 32'd5);
        // Other grants and release bits for other IDs are ignored during HOLD
        grant     = 4'b1011;
        release_i = 8'hDF;
        rd_sel    = 3'd3;
        step();
        chk("g5_ign_ch_en", 32'(ch_en), 32'h20);
        chk("g5_ign_owner", 32'(owner_id), 32'd5);
        chk("g5_ign_done", 32'(done_pulse), 32'd0);
        chk("g5_ign_served3", 32'(served_cnt), 32'd0);
        grant     = 4'h0;
        release_i = 8'h20;
        step();
        chk("r5_done", 32'(done_pulse), 32'd1);
        release_i = 8'h00;
        step();
        step();
        chk("r5_idle", 32'(busy), 32'd0);

        // Owner 4 holds without releasing: 16 cycles of ch_en, then a timeout
        grant = 4'b1100;
        step();
        chk("g4_c1_ch_en", 32'(ch_en), 32'h10);
        grant = 4'h0;
        for (int i = 2; i <= 16; i++) begin
            step();
            chk("g4_hold_ch_en", 32'(ch_en), 32'h10);
            chk("g4_hold_tmo", 32'(timeout_pulse), 32'd0);
        end
        step();
        chk("t4_ch_en", 32'(ch_en), 32'h00);
        chk("t4_tmo", 32'(timeout_pulse), 32'd1);
        chk("t4_done", 32'(done_pulse), 32'd0);
        step();
        chk("t4_tmo_once", 32'(timeout_pulse), 32'd0);
        chk("t4_guard_busy", 32'(busy), 32'd1);
        step();
        chk("t4_idle", 32'(busy), 32'd0);

        // Owner 6 releases in the last allowed cycle, so the release takes priority over the timeout
        grant = 4'b1110;
        step();
        grant = 4'h0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("g6_c16_ch_en", 32'(ch_en), 32'h40);
        release_i = 8'h40;
        step();
        chk("r6_done", 32'(done_pulse), 32'd1);
        chk("r6_tmo", 32'(timeout_pulse), 32'd0);
        release_i = 8'h00;
        step();
        step();

        // Owner 1 with an intruding grant for ID 3 and a release for ID 3
        grant = 4'b1001;
        step();
        grant     = 4'b1011;
        release_i = 8'h08;
        rd_sel    = 3'd3;
        step();
        chk("g1_owner", 32'(owner_id), 32'd1);
        chk("g1_ch_en", 32'(ch_en), 32'h02);
        chk("g1_no_pulse", 32'({done_pulse, timeout_pulse}), 32'd0);
        chk("g1_served3", 32'(served_cnt), 32'd0);
        grant     = 4'h0;
        release_i = 8'h02;
        step();
        chk("r1_done", 32'(done_pulse), 32'd1);
        release_i = 8'h00;
        step();
        step();

        // 300 grants to ID 0. Each takes 4 edges, so the 300th accept lands on edge 1197.
        grant     = 4'b1000;
        release_i = 8'h01;
        rd_sel    = 3'd0;
        for (int i = 0; i < 1197; i++) begin
            step();
            if (done_pulse && timeout_pulse) begin
                chk("pulse_overlap", 32'({done_pulse, timeout_pulse}), 32'd0);
            end
        end
        grant     = 4'h0;
        release_i = 8'h00;
        chk("sat_served0", 32'(served_cnt), 32'd255);
        chk("sat_ch_en", 32'(ch_en), 32'h01);
        step();
        chk("sat_hold_ch_en", 32'(ch_en), 32'h01);

        // Asserting reset mid-HOLD clears everything at once and does not pulse
        rst_n = 1'b0;
        #1;
        chk("mrst_ch_en", 32'(ch_en), 32'h00);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_served0", 32'(served_cnt), 32'd0);
        rd_sel = 3'd7;
        #1;
        chk("mrst_served7", 32'(served_cnt), 32'd0);
        step();
        chk("mrst_pulses", 32'({done_pulse, timeout_pulse}), 32'd0);
        chk("mrst_owner", 32'(owner_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/grant_channel_ctrl.md
GRANT_CHANNEL_CTRL -- requirements
Module: grant_channel_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum cycles one owner holds the channel before forced release; legal range 2..255.
REQ-002 Parameter GUARD, default 2, idle cycles inserted between owners; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 grant  input  4  arbiter result; grant[3] is valid, grant[2:0] is the granted ID 0..7.
REQ-006 release_i  input  8  per-ID release request; bit k is meaningful only while ID k owns the channel.
REQ-007 rd_sel  input  3  selects the ID whose served count appears on served_cnt.
REQ-008 ch_en  output  8  one-hot channel enable for the current owner; all zero when no owner.
REQ-009 owner_id  output  3  ID of the current or most recent owner.
REQ-010 busy  output  1  high in HOLD and GUARD states.
REQ-011 done_pulse  output  1  one-cycle pulse on voluntary release.
REQ-012 timeout_pulse  output  1  one-cycle pulse on forced release at MAX_HOLD.
REQ-013 served_cnt  output  8  served count of ID rd_sel; combinational read of registered counters.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, HOLD, GUARD.
REQ-015 IDLE: on a rising edge with grant[3]=1, SHALL move to HOLD, register owner_id=grant[2:0], set ch_en bit grant[2:0], clear hold_cnt to 0.
REQ-016 Latency: ch_en, owner_id and busy SHALL change on the same edge that samples the grant (zero added cycles beyond the registering edge).
REQ-017 IDLE with grant[3]=0 SHALL remain in IDLE with ch_en=0 and busy=0.
REQ-018 HOLD: hold_cnt SHALL increment by 1 every cycle the FSM stays in HOLD.
REQ-019 HOLD: if release_i[owner_id]=1, SHALL go to GUARD, clear ch_en, and assert done_pulse for exactly the following cycle.
REQ-020 HOLD: if hold_cnt==MAX_HOLD-1 with no release, SHALL go to GUARD, clear ch_en, and assert timeout_pulse for one cycle; ch_en is high for exactly MAX_HOLD cycles.
REQ-021 Release and timeout in the same cycle: release wins; done_pulse=1 and timeout_pulse=0.
REQ-022 release_i bits other than owner_id SHALL be ignored.
REQ-023 grant SHALL be ignored (not queued) in HOLD and GUARD.
REQ-024 GUARD: SHALL stay GUARD cycles with ch_en=0 and busy=1, then return to IDLE; with GUARD=0, HOLD exits directly to IDLE.
REQ-025 A grant present on the edge that enters IDLE from GUARD SHALL not be accepted; acceptance starts on the first edge with state IDLE.
REQ-026 Per-ID 8-bit served counter SHALL increment on each IDLE->HOLD transition for that ID and saturate at 255.
REQ-027 owner_id SHALL hold its last value through GUARD and IDLE.
REQ-028 done_pulse and timeout_pulse SHALL never be high together, and neither for more than one cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, ch_en=0, owner_id=0, busy=0, done_pulse=0, timeout_pulse=0, hold_cnt=0, all served counters=0.
REQ-030 Reset asserted mid-HOLD SHALL drop ch_en without pulsing done_pulse or timeout_pulse.
REQ-031 After rst_n rises, the first grant SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-032 Reset, then grant=4'b1111 for one cycle -> next edge ch_en=8'h80, owner_id=7, busy=1; served_cnt(rd_sel=7)=1.
REQ-033 Owner 2 granted, release_i=8'h04 after 3 cycles -> ch_en=0, done_pulse high one cycle, busy high 2 more cycles (GUARD=2), then IDLE.
REQ-034 Owner 4 granted, no release -> ch_en=8'h10 for exactly 16 cycles, timeout_pulse one cycle, no done_pulse.
REQ-035 During HOLD by ID 1, grant=4'b1011 and release_i=8'h08 -> owner stays 1, ch_en=8'h02, no pulses; served_cnt(3) unchanged.
REQ-036 Release on cycle hold_cnt=15 -> done_pulse=1, timeout_pulse=0.
REQ-037 Grant ID 0 300 times -> served_cnt(rd_sel=0)=255; rst_n pulsed low mid-HOLD -> all outputs 0 at once, served_cnt=0.
